// File: rtl/input_debouncer_pkg.sv
// Shared constants, state type and sizing helpers for the pushbutton/switch debouncer.
// WIDTH is limited to 32 channels by the released-level helper.
package input_debouncer_pkg;

  localparam int unsigned DEB_CLK_HZ             = 50_000_000;
  localparam int unsigned DEB_STABLE_CYCLES_10MS = 500000;

  typedef enum logic {
    StStable,
    StPending
  } deb_state_e;

  // Ceiling log2, never less than 1 so a counter always has at least one bit.
  function automatic int unsigned deb_clog2(input int unsigned value);
    int unsigned result;
    int unsigned v;
    result = 0;
    v      = (value > 0) ? value - 1 : 0;
    while (v > 0) begin
      result++;
      v = v >> 1;
    end
    return (result == 0) ? 1 : result;
  endfunction

  // Idle (not pressed) level for each of the first `width` channels.
  function automatic logic [31:0] deb_released_level(input bit active_low,
                                                     input int unsigned width);
    logic [31:0] result;
    result = '0;
    for (int i = 0; i < 32; i++) begin
      if (i < width) begin
        result[i] = active_low;
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/input_debouncer_channel.sv
// Single-bit debouncer: synchronizer, saturating stability counter and 2-state FSM.
// The level, press and release outputs all come straight from flops.
module debounce_channel
  import input_debouncer_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = DEB_STABLE_CYCLES_10MS,
  parameter int unsigned SYNC_STAGES   = 2,
  parameter logic        RELEASED      = 1'b1
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_raw,
  output logic o_level,
  output logic o_press,
  output logic o_release
);

  localparam int unsigned     CntW    = deb_clog2(STABLE_CYCLES + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(STABLE_CYCLES - 1);
  localparam logic [CntW-1:0] CntMax  = CntW'(STABLE_CYCLES);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   w_sync;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync <= {SYNC_STAGES{RELEASED}};
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_raw};
    end
  end

  assign w_sync = r_sync[SYNC_STAGES-1];

  deb_state_e      w_state;
  logic [CntW-1:0] r_cnt;
  logic [CntW-1:0] w_cnt_next;
  logic            r_level;
  logic            w_level_next;
  logic            w_accept;
  logic            r_press;
  logic            r_release;
  logic            w_press_next;
  logic            w_release_next;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt     <= '0;
      r_level   <= RELEASED;
      r_press   <= 1'b0;
      r_release <= 1'b0;
    end else begin
      r_cnt     <= w_cnt_next;
      r_level   <= w_level_next;
      r_press   <= w_press_next;
      r_release <= w_release_next;
    end
  end

  // The state is the disagreement between the synchronized input and the accepted level.
  always_comb begin
    w_state      = (w_sync != r_level) ? StPending : StStable;
    w_accept     = 1'b0;
    w_cnt_next   = '0;
    w_level_next = r_level;
    unique case (w_state)
      StStable: begin
        w_cnt_next = '0;
      end
      StPending: begin
        if (r_cnt == CntLast) begin
          w_accept     = 1'b1;
          w_level_next = w_sync;
        end else if (r_cnt != CntMax) begin
          w_cnt_next = r_cnt + 1'b1;
        end else begin
          w_cnt_next = r_cnt;
        end
      end
      default: begin
        w_cnt_next = '0;
      end
    endcase
  end

  always_comb begin
    w_press_next   = w_accept && (w_sync != RELEASED);
    w_release_next = w_accept && (w_sync == RELEASED);
  end

  assign o_level   = r_level;
  assign o_press   = r_press;
  assign o_release = r_release;

endmodule

// File: rtl/input_debouncer.sv
// Multi-channel debouncer feeding the pushbuttons PIO, with press/release pulses and a
// sticky per-channel edge-capture register.
module input_debouncer
  import input_debouncer_pkg::*;
#(
  parameter int unsigned WIDTH         = 4,
  parameter int unsigned STABLE_CYCLES = DEB_STABLE_CYCLES_10MS,
  parameter bit          ACTIVE_LOW    = 1'b1,
  parameter int unsigned SYNC_STAGES   = 2
) (
  input  logic             clk_clk,
  input  logic             reset_reset_n,
  input  logic [WIDTH-1:0] raw_in,
  output logic [WIDTH-1:0] debounced_out,
  output logic [WIDTH-1:0] press_pulse,
  output logic [WIDTH-1:0] release_pulse,
  output logic [WIDTH-1:0] edge_capture,
  input  logic [WIDTH-1:0] edge_clear
);

  localparam logic [WIDTH-1:0] ReleasedVec = WIDTH'(deb_released_level(ACTIVE_LOW, WIDTH));

  logic [WIDTH-1:0] w_level;
  logic [WIDTH-1:0] w_press;
  logic [WIDTH-1:0] w_release;
  logic [WIDTH-1:0] r_edge_capture;

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_chan
    debounce_channel #(
      .STABLE_CYCLES(STABLE_CYCLES),
      .SYNC_STAGES  (SYNC_STAGES),
      .RELEASED     (ReleasedVec[gi])
    ) u_chan (
      .i_clk    (clk_clk),
      .i_rst_n  (reset_reset_n),
      .i_raw    (raw_in[gi]),
      .o_level  (w_level[gi]),
      .o_press  (w_press[gi]),
      .o_release(w_release[gi])
    );
  end

  // A press arriving together with a clear keeps the flag set so no press is lost.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      r_edge_capture <= '0;
    end else begin
      r_edge_capture <= (r_edge_capture & ~edge_clear) | w_press;
    end
  end

  assign debounced_out = w_level;
  assign press_pulse   = w_press;
  assign release_pulse = w_release;
  assign edge_capture  = r_edge_capture;

endmodule
